// File: rtl/datamem_pipe.sv
// Pipelined byte-addressable little-endian data memory for the MEM stage.
// Valid/ready request side, fixed-latency in-order response pipeline with
// backpressure, load sign/zero extension and error reporting for illegal
// (bad size, misaligned, out-of-range) accesses.
module datamem_pipe #(
  parameter int unsigned MEM_BYTES    = 1024,
  parameter int unsigned DATA_BYTES   = 8,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [3:0]              req_size,
  input  logic                    req_signed,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_write,
  output logic [8*DATA_BYTES-1:0] resp_rdata,
  output logic                    resp_err,
  output logic [15:0]             err_count
);

  localparam int unsigned DW    = 8 * DATA_BYTES;
  localparam int unsigned IDX_W = $clog2(MEM_BYTES);
  localparam int unsigned LAT   = READ_LATENCY;

  // Reject parameter combinations the datapath cannot represent
  generate
    if (MEM_BYTES < 2 || (MEM_BYTES & (MEM_BYTES - 1)) != 0 || MEM_BYTES <= DATA_BYTES) begin : g_bad_mem
      $error("datamem_pipe: MEM_BYTES must be a power of two greater than DATA_BYTES");
    end
    if (DATA_BYTES != 1 && DATA_BYTES != 2 && DATA_BYTES != 4 && DATA_BYTES != 8) begin : g_bad_data
      $error("datamem_pipe: DATA_BYTES must be 1, 2, 4 or 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("datamem_pipe: READ_LATENCY must be in 1..4");
    end
    if (ADDR_W < IDX_W) begin : g_bad_addr
      $error("datamem_pipe: ADDR_W too narrow for MEM_BYTES");
    end
  endgenerate

  logic [7:0]       mem [MEM_BYTES];

  logic             stall;
  logic             accept;
  logic             size_ok;
  logic             misaligned;
  logic             over_range;
  logic             req_err;
  logic [ADDR_W:0]  end_addr;
  logic [IDX_W-1:0] base_idx;
  logic [DW-1:0]    load_data;

  logic             st_valid [LAT];
  logic             st_write [LAT];
  logic             st_err   [LAT];
  logic [DW-1:0]    st_data  [LAT];

  // Handshake: the whole pipeline freezes while the response is refused
  always_comb begin
    stall     = resp_valid & ~resp_ready;
    req_ready = ~stall;
    accept    = req_valid & req_ready & ~reset;
  end

  // Legality of the incoming request; end address computed one bit wider so it cannot wrap
  always_comb begin
    size_ok = 1'b0;
    case (req_size)
      4'd1, 4'd2, 4'd4, 4'd8: size_ok = (32'(req_size) <= DATA_BYTES);
      default:                size_ok = 1'b0;
    endcase
    misaligned = (req_addr & (ADDR_W'(req_size) - ADDR_W'(1))) != '0;
    end_addr   = {1'b0, req_addr} + (ADDR_W+1)'(req_size);
    over_range = end_addr > (ADDR_W+1)'(MEM_BYTES);
    req_err    = ~size_ok | misaligned | over_range;
    base_idx   = req_addr[IDX_W-1:0];
  end

  // Combinational array read with extension of the bytes above the transfer size
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             sign;
    load_data = '0;
    idx       = '0;
    sign      = 1'b0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      idx = base_idx + IDX_W'(i);
      if (i < int'(req_size)) begin
        load_data[8*i +: 8] = mem[idx];
        sign                = mem[idx][7];
      end else begin
        load_data[8*i +: 8] = {8{sign & req_signed}};
      end
    end
  end

  // Byte-lane store on the acceptance edge; errored stores leave memory untouched
  always_ff @(posedge clk) begin
    if (accept & req_write & ~req_err) begin
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
        if (i < int'(req_size)) begin
          mem[base_idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures the accepted request, later stages shift unless stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(LAT); k++) begin
        st_valid[k] <= 1'b0;
        st_write[k] <= 1'b0;
        st_err[k]   <= 1'b0;
        st_data[k]  <= '0;
      end
    end else if (!stall) begin
      st_valid[0] <= accept;
      st_write[0] <= accept & req_write;
      st_err[0]   <= accept & req_err;
      st_data[0]  <= (accept & ~req_write & ~req_err) ? load_data : '0;
      for (int k = 1; k < int'(LAT); k++) begin
        st_valid[k] <= st_valid[k-1];
        st_write[k] <= st_write[k-1];
        st_err[k]   <= st_err[k-1];
        st_data[k]  <= st_data[k-1];
      end
    end
  end

  // Saturating count of errored requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 16'd0;
    end else if (accept && req_err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

  // Last stage drives the response port directly
  always_comb begin
    resp_valid = st_valid[LAT-1];
    resp_write = st_write[LAT-1];
    resp_err   = st_err[LAT-1];
    resp_rdata = st_data[LAT-1];
  end

endmodule

// File: tb/tb_datamem_pipe.sv
// Directed and small randomised self-checking bench for datamem_pipe
// (default parameters: 1024 bytes, 8-byte words, latency 2).
module tb_datamem_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_write;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;
  int model_errs;

  logic [7:0]  ref_mem [1024];
  logic [63:0] exp_data_q [$];
  logic        exp_write_q [$];
  logic        exp_err_q [$];
  logic [63:0] bp_addr [6];
  logic [63:0] bp_data [6];
  logic [3:0]  sz_tab [10];

  datamem_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated request: accept, measure latency, check response, drain
  task automatic txn(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                     input logic sgn, input logic [63:0] wdata, input logic exp_err,
                     input logic [63:0] exp_data, input logic [15:0] exp_ec, input string tag);
    int cnt;
    req_write  = wr;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check({tag, ".ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cnt = 1;
    while (!resp_valid && cnt < 12) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, ".lat"}, 64'(cnt), 64'd2);
    check({tag, ".write"}, 64'(resp_write), 64'(wr));
    check({tag, ".err"}, 64'(resp_err), 64'(exp_err));
    check({tag, ".data"}, resp_rdata, exp_data);
    check({tag, ".errcnt"}, 64'(err_count), 64'(exp_ec));
    @(posedge clk);
    #1;
    check({tag, ".drain"}, 64'(resp_valid), 64'd0);
  endtask

  // Reference model: evaluate an accepted request and queue its expected response
  task automatic model_accept(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                              input logic sgn, input logic [63:0] wdata);
    logic        err;
    logic [64:0] endp;
    logic [63:0] d;
    logic        sb;
    int          base;
    err = !(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8);
    if (!err && (addr % 64'(size)) != 64'd0) err = 1'b1;
    endp = {1'b0, addr} + 65'(size);
    if (endp > 65'd1024) err = 1'b1;
    if (err) model_errs++;
    d    = 64'd0;
    sb   = 1'b0;
    base = int'(addr[9:0]);
    if (!err && wr) begin
      for (int i = 0; i < int'(size); i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else if (!err) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(size)) begin
          d[8*i +: 8] = ref_mem[base + i];
          sb          = ref_mem[base + i][7];
        end else begin
          d[8*i +: 8] = sgn ? {8{sb}} : 8'h00;
        end
      end
    end
    exp_write_q.push_back(wr);
    exp_err_q.push_back(err);
    exp_data_q.push_back(d);
  endtask

  // Streamed traffic: mode 0 = backpressure test, mode 1 = prefill + random sweep
  task automatic stream(input int mode, input int n, input int err0);
    int   idx = 0;
    int   cyc = 0;
    int   stall_cycles = 0;
    int   r;
    logic have = 1'b0;
    logic acc;
    model_errs = err0;
    exp_data_q.delete();
    exp_write_q.delete();
    exp_err_q.delete();
    while ((idx < n || exp_err_q.size() != 0) && cyc < 3000) begin
      if (mode == 0) resp_ready = !(cyc >= 3 && cyc < 6);
      else           resp_ready = ($urandom_range(0, 3) != 0);
      if (!have && idx < n) begin
        have       = 1'b1;
        req_signed = 1'(($urandom_range(0, 1)));
        req_wdata  = {$urandom, $urandom};
        if (mode == 0) begin
          req_write = 1'b0;
          req_addr  = bp_addr[idx];
          req_size  = 4'd8;
        end else if (idx < 16) begin
          req_write = 1'b1;
          req_addr  = 64'h100 + 64'(8 * idx);
          req_size  = 4'd8;
        end else if (idx == 16) begin
          req_write = 1'b1;
          req_addr  = 64'h3F8;
          req_size  = 4'd8;
        end else begin
          req_write = 1'(($urandom_range(0, 1)));
          req_size  = sz_tab[$urandom_range(0, 9)];
          r = $urandom_range(0, 9);
          if (r < 7)      req_addr = 64'h100 + 64'($urandom_range(0, 127));
          else if (r < 9) req_addr = 64'h3F8 + 64'($urandom_range(0, 15));
          else            req_addr = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        end
      end
      req_valid = have;
      @(negedge clk);
      check("stream.ready", 64'(req_ready), 64'(!(resp_valid && !resp_ready)));
      if (resp_valid && !resp_ready) stall_cycles++;
      if (resp_valid && resp_ready) begin
        if (exp_err_q.size() == 0) begin
          check("stream.extra_resp", 64'(resp_valid), 64'd0);
        end else begin
          check("stream.write", 64'(resp_write), 64'(exp_write_q.pop_front()));
          check("stream.err", 64'(resp_err), 64'(exp_err_q.pop_front()));
          check("stream.data", resp_rdata, exp_data_q.pop_front());
        end
      end
      acc = req_valid && req_ready;
      if (acc) begin
        if (mode == 0) begin
          exp_write_q.push_back(1'b0);
          exp_err_q.push_back(1'b0);
          exp_data_q.push_back(bp_data[idx]);
        end else begin
          model_accept(req_write, req_addr, req_size, req_signed, req_wdata);
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        have = 1'b0;
      end
      cyc++;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check("stream.issued", 64'(idx), 64'(n));
    check("stream.pending", 64'(exp_err_q.size()), 64'd0);
    check("stream.errcnt", 64'(err_count), 64'(model_errs));
    if (mode == 0) check("stream.stall_cycles", 64'(stall_cycles), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("stream.idle", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    bp_addr = '{64'h00, 64'h10, 64'h3F8, 64'h10, 64'h00, 64'h3F8};
    bp_data = '{64'h0123456789ABCDEF, 64'h1122334455667788, 64'hCAFEF00D12345678,
                64'h1122334455667788, 64'h0123456789ABCDEF, 64'hCAFEF00D12345678};
    sz_tab  = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_size   = 4'd0;
    req_signed = 1'b0;
    req_wdata  = 64'd0;
    resp_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    check("rst.valid", 64'(resp_valid), 64'd0);
    check("rst.write", 64'(resp_write), 64'd0);
    check("rst.err", 64'(resp_err), 64'd0);
    check("rst.rdata", resp_rdata, 64'd0);
    check("rst.errcnt", 64'(err_count), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic store/load and extension
    txn(1'b1, 64'h10, 4'd8, 1'b0, 64'h1122334455667788, 1'b0, 64'd0, 16'd0, "st8");
    txn(1'b0, 64'h10, 4'd8, 1'b0, 64'd0, 1'b0, 64'h1122334455667788, 16'd0, "ld8");
    txn(1'b0, 64'h10, 4'd1, 1'b0, 64'd0, 1'b0, 64'h88, 16'd0, "ld1u");
    txn(1'b0, 64'h10, 4'd1, 1'b1, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF88, 16'd0, "ld1s");
    txn(1'b0, 64'h12, 4'd2, 1'b1, 64'd0, 1'b0, 64'h5566, 16'd0, "ld2s");

    // Errors leave memory untouched and bump the counter
    txn(1'b1, 64'h00, 4'd8, 1'b0, 64'h0123456789ABCDEF, 1'b0, 64'd0, 16'd0, "st8z");
    txn(1'b1, 64'h06, 4'd4, 1'b0, 64'hDEADBEEF, 1'b1, 64'd0, 16'd1, "st4mis");
    txn(1'b0, 64'h00, 4'd8, 1'b0, 64'd0, 1'b0, 64'h0123456789ABCDEF, 16'd1, "ld8z");
    txn(1'b0, 64'h00, 4'd2, 1'b1, 64'd0, 1'b0, 64'hFFFFFFFFFFFFCDEF, 16'd1, "ld2s_neg");
    txn(1'b1, 64'h3F8, 4'd8, 1'b0, 64'hCAFEF00D12345678, 1'b0, 64'd0, 16'd1, "st8top");
    txn(1'b0, 64'h3F8, 4'd8, 1'b0, 64'd0, 1'b0, 64'hCAFEF00D12345678, 16'd1, "ld8top");
    txn(1'b0, 64'h3FC, 4'd4, 1'b1, 64'd0, 1'b0, 64'hFFFFFFFFCAFEF00D, 16'd1, "ld4top");
    txn(1'b0, 64'h400, 4'd8, 1'b0, 64'd0, 1'b1, 64'd0, 16'd2, "ld8oob");
    txn(1'b0, 64'h20, 4'd3, 1'b0, 64'd0, 1'b1, 64'd0, 16'd3, "ld3");
    txn(1'b0, 64'h11, 4'd2, 1'b0, 64'd0, 1'b1, 64'd0, 16'd4, "ld2mis");
    txn(1'b1, 64'hFFFFFFFFFFFFFFF8, 4'd8, 1'b0, 64'h1, 1'b1, 64'd0, 16'd5, "st8wrap");
    txn(1'b0, 64'h20, 4'd0, 1'b0, 64'd0, 1'b1, 64'd0, 16'd6, "ld0");
    txn(1'b0, 64'h3F8, 4'd8, 1'b0, 64'd0, 1'b0, 64'hCAFEF00D12345678, 16'd6, "ld8top2");

    // Backpressure: six back-to-back loads, consumer stalls three cycles
    stream(0, 6, 6);

    // Asynchronous reset with responses in flight
    req_write  = 1'b1;
    req_addr   = 64'h80;
    req_size   = 4'd8;
    req_signed = 1'b0;
    req_wdata  = 64'h0F1E2D3C4B5A6978;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 req_write = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("mid.pre_valid", 64'(resp_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("mid.valid", 64'(resp_valid), 64'd0);
    check("mid.errcnt", 64'(err_count), 64'd0);
    check("mid.rdata", resp_rdata, 64'd0);
    req_write = 1'b1;
    req_wdata = 64'd0;
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid.hold_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b0, 64'h80, 4'd8, 1'b0, 64'd0, 1'b0, 64'h0F1E2D3C4B5A6978, 16'd0, "mid.reload");

    // Prefill then random traffic against the byte-array model
    stream(1, 417, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
